// File: rtl/matrix_message_source_if.sv
// Message bundle between the upstream producer, the message buffer
// and the processor's matrix-init consumer port.
interface matrix_message_source_if #(
    parameter int MATRIX_TYPE_BITS    = 1,
    parameter int MATRIX_COORD_BITS   = 8,
    parameter int MATRIX_ELEMENT_BITS = 32,
    parameter int FIFO_DEPTH          = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [MATRIX_TYPE_BITS-1:0]    in_type;
    logic [MATRIX_COORD_BITS-1:0]   in_x_coord;
    logic [MATRIX_COORD_BITS-1:0]   in_y_coord;
    logic [MATRIX_ELEMENT_BITS-1:0] in_element;
    logic                           in_valid;
    logic                           in_ready;

    logic [MATRIX_TYPE_BITS-1:0]    matrix_type_out;
    logic [MATRIX_COORD_BITS-1:0]   matrix_x_coord_out;
    logic [MATRIX_COORD_BITS-1:0]   matrix_y_coord_out;
    logic [MATRIX_ELEMENT_BITS-1:0] matrix_element_out;
    logic                           message_out_valid;
    logic                           message_out_available;
    logic                           message_in_read;
    logic [CW-1:0]                  count;
    logic                           underflow;

    modport slave (
        input  in_type, in_x_coord, in_y_coord, in_element,
        input  in_valid, message_in_read,
        output in_ready,
        output matrix_type_out, matrix_x_coord_out,
        output matrix_y_coord_out, matrix_element_out,
        output message_out_valid, message_out_available,
        output count, underflow
    );

    modport master (
        output in_type, in_x_coord, in_y_coord, in_element,
        output in_valid, message_in_read,
        input  in_ready,
        input  matrix_type_out, matrix_x_coord_out,
        input  matrix_y_coord_out, matrix_element_out,
        input  message_out_valid, message_out_available,
        input  count, underflow
    );
endinterface

// File: rtl/matrix_message_source.sv
// Circular message buffer feeding the processor's matrix-init inputs,
// with a registered head and a one-cycle settling bubble after each pop.
module matrix_message_source #(
    parameter int MATRIX_TYPE_BITS    = 1,
    parameter int MATRIX_COORD_BITS   = 8,
    parameter int MATRIX_ELEMENT_BITS = 32,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic clk,
    input  logic reset,
    matrix_message_source_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int MW = MATRIX_TYPE_BITS + 2 * MATRIX_COORD_BITS
                      + MATRIX_ELEMENT_BITS;

    typedef logic [MW-1:0] msg_t;

    msg_t          mem [FIFO_DEPTH];
    msg_t          in_msg;
    msg_t          head_q;
    msg_t          head_next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          pop_last;
    logic          available_q;
    logic          underflow_q;
    logic          push;
    logic          pop;
    logic          empty;

    assign in_msg = {bus.in_type, bus.in_x_coord,
                     bus.in_y_coord, bus.in_element};

    assign empty        = (count_q == '0);
    assign bus.in_ready = (count_q != CW'(FIFO_DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.message_in_read && !empty;

    // Head follows the post-edge read pointer; an entry written this
    // edge at that slot is forwarded since the array is not yet updated.
    always_comb begin
        rd_next    = rd_ptr;
        count_next = count_q;
        head_next  = head_q;
        if (pop) rd_next = rd_ptr + 1'b1;
        unique case ({push, pop})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
        if (count_next != '0) begin
            if (push && (wr_ptr == rd_next)) head_next = in_msg;
            else                             head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= in_msg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            pop_last    <= 1'b0;
            available_q <= 1'b0;
            underflow_q <= 1'b0;
            head_q      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr      <= rd_next;
            count_q     <= count_next;
            pop_last    <= pop;
            available_q <= (count_next != '0);
            head_q      <= head_next;
            if (bus.message_in_read && empty) underflow_q <= 1'b1;
        end
    end

    assign {bus.matrix_type_out, bus.matrix_x_coord_out,
            bus.matrix_y_coord_out, bus.matrix_element_out} = head_q;

    assign bus.message_out_available = available_q;
    assign bus.message_out_valid     = available_q && !pop_last;
    assign bus.count                 = count_q;
    assign bus.underflow             = underflow_q;
endmodule

// File: doc/matrix_message_source.md
MATRIX_MESSAGE_SOURCE -- requirements
Module: matrix_message_source

Interface
REQ-001 SHALL have parameter MATRIX_TYPE_BITS, default 1, width of message type field.
REQ-002 SHALL have parameter MATRIX_COORD_BITS, default 8, width of each coordinate field.
REQ-003 SHALL have parameter MATRIX_ELEMENT_BITS, default 32, width of element field.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, message buffer entries; power of 2, >= 2.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports in_type, in_x_coord, in_y_coord, in_element, inputs, parameter widths, upstream message fields.
REQ-008 SHALL have port in_valid, input, 1, upstream message present.
REQ-009 SHALL have port in_ready, output, 1, buffer accepts a message this cycle.
REQ-010 SHALL have ports matrix_type_out, matrix_x_coord_out, matrix_y_coord_out, matrix_element_out, outputs, parameter widths, head message presented to the processor's matrix-init inputs.
REQ-011 SHALL have port message_out_valid, output, 1, head fields stable and coherent.
REQ-012 SHALL have port message_out_available, output, 1, buffer non-empty.
REQ-013 SHALL have port message_in_read, input, 1, one-cycle pop strobe from the processor.
REQ-014 SHALL have port count, output, $clog2(FIFO_DEPTH)+1, entries held.
REQ-015 SHALL have port underflow, output, 1, sticky: pop seen while empty.

Function
REQ-016 SHALL store messages in a FIFO_DEPTH-entry circular buffer with write pointer, read pointer, and count register.
REQ-017 SHALL drive in_ready = (count != FIFO_DEPTH), combinational from count only; no same-cycle pop bypass.
REQ-018 SHALL push {type, x, y, element} on a cycle with in_valid && in_ready; count +1; write pointer wraps FIFO_DEPTH-1 -> 0.
REQ-019 SHALL pop on a cycle with message_in_read && count != 0; count -1; read pointer wraps FIFO_DEPTH-1 -> 0.
REQ-020 SHALL, on simultaneous push and pop, update both pointers and leave count unchanged.
REQ-021 SHALL, on message_in_read with count == 0, ignore the pop (pointers/count unchanged) and set underflow, even when a push occurs that cycle.
REQ-022 SHALL present the entry at the read pointer on the four output fields, registered; fields update the cycle after any pointer change.
REQ-023 SHALL drive message_out_available = (count != 0), registered; a push into empty buffer at edge N yields available at N+1.
REQ-024 SHALL drive message_out_valid = available && !pop_last, where pop_last is a register set for exactly one cycle after a successful pop (settling bubble).
REQ-025 SHALL hold the output fields while count == 0 at their last value; content then undefined to consumers.
REQ-026 SHALL not alter the buffer contents on a dropped upstream message (in_valid && !in_ready); upstream holds the message.
REQ-027 SHALL keep underflow set until reset.

Reset
REQ-028 SHALL, while reset is high at a clock edge, clear pointers, count, pop_last, underflow, message_out_valid, message_out_available, and all output fields to 0; in_ready = 1 after reset.
REQ-029 SHALL ignore in_valid and message_in_read during reset; a reset mid-stream discards all buffered messages.

Verification
REQ-030 Push {type=1,x=3,y=5,element=0xDEADBEEF} into empty FIFO -> available=1 and valid=1 next cycle, fields show that message, count=1.
REQ-031 Push 4 messages with DEPTH=4, no pops -> count=4, in_ready=0; 5th in_valid held -> not stored; after one pop in_ready=1, 5th accepted.
REQ-032 Pop with 2 entries -> valid=0 one cycle, then valid=1 with second message, count=1.
REQ-033 Push and pop same cycle at count=2 -> count stays 2; 10 push/pop pairs -> pointers wrap, order preserved, no loss.
REQ-034 Pop while empty -> count stays 0, underflow=1 and remains 1 through later traffic until reset.
REQ-035 Reset asserted with count=3 -> next cycle count=0, available=0, valid=0, underflow=0, in_ready=1, fields 0.
